// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl
// Sequencer between the CPU load/store unit and a single-port synchronous RAM.
// It takes one read or write per valid/ready handshake, drives the RAM
// control lines and the shared data bus, and hands read data back through a
// response channel that holds its value until the CPU consumes it. Each
// access holds the RAM bus for 1 + WAIT_STATES cycles.
//
// Ports
//   clk         system clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   req_valid   CPU request present
//   req_ready   controller accepts a request this cycle
//   req_we      1 = write, 0 = read
//   req_addr    word address
//   req_wdata   write data
//   resp_valid  read data available
//   resp_ready  CPU consumes the response
//   resp_rdata  read data
//   mem_addr    RAM address
//   mem_data    RAM bidirectional data bus
//   mem_cs      RAM chip select
//   mem_we      RAM write enable
//   mem_oe      RAM output enable
//
// state | meaning
// IDLE  | req_ready high, waiting for a handshake
// WRITE | driving cs/we and the data bus for 1 + WAIT_STATES cycles
// READ  | driving cs/oe, RAM owns the data bus
// RESP  | holding resp_valid/resp_rdata until resp_ready

module ram_bus_ctrl #(
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Wait-state count is limited to 0..15, so four bits hold it.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bus_drive;

  // The bus enable is a registered flop set only on entry to WRITE and
  // cleared on its exit, so the controller and the RAM (which drives only
  // while cs & oe & !we) never own the bus in the same cycle.
  assign mem_data = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      wdata_q    <= '0;
      bus_drive  <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            wdata_q   <= req_wdata;
            wait_cnt  <= WAIT_LOAD;
            mem_cs    <= 1'b1;
            if (req_we) begin
              mem_we    <= 1'b1;
              bus_drive <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_oe <= 1'b1;
              state  <= READ;
            end
          end
        end

        // The RAM commits on every posedge with cs & we, so repeating the
        // same write through the wait states is harmless.
        WRITE: begin
          if (wait_cnt == 4'd0) begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            bus_drive <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        // The RAM latches the address on the negedge and drives the bus, so
        // the value is stable by the posedge where the counter expires.
        READ: begin
          if (wait_cnt == 4'd0) begin
            resp_rdata <= mem_data;
            resp_valid <= 1'b1;
            mem_cs     <= 1'b0;
            mem_oe     <= 1'b0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
module tb_ram_bus_ctrl;

  // Instance 0 runs with no wait states, instance 1 with three.
  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  wire  [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][21:0] req_addr;
  logic [1:0][15:0] req_wdata;
  wire  [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  wire  [1:0][15:0] resp_rdata;
  wire  [1:0][21:0] mem_addr;
  wire  [1:0]       mem_cs;
  wire  [1:0]       mem_we;
  wire  [1:0]       mem_oe;
  wire  [1:0][15:0] bus_seen;

  int total;
  int bad;
  int overlap_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g
    wire [15:0] bus;
    logic [15:0] store [int unsigned];
    logic [15:0] rd_q = 16'h0000;
    wire ram_drv = mem_cs[i] & mem_oe[i] & ~mem_we[i];

    ram_bus_ctrl #(
      .ADDR_WIDTH (22),
      .DATA_WIDTH (16),
      .WAIT_STATES(i == 0 ? 0 : 3)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[i]),
      .req_ready (req_ready[i]),
      .req_we    (req_we[i]),
      .req_addr  (req_addr[i]),
      .req_wdata (req_wdata[i]),
      .resp_valid(resp_valid[i]),
      .resp_ready(resp_ready[i]),
      .resp_rdata(resp_rdata[i]),
      .mem_addr  (mem_addr[i]),
      .mem_data  (bus),
      .mem_cs    (mem_cs[i]),
      .mem_we    (mem_we[i]),
      .mem_oe    (mem_oe[i])
    );

    // Behavioural single-port synchronous RAM.
    assign bus = ram_drv ? rd_q : 16'hzzzz;
    assign bus_seen[i] = bus;

    always @(posedge clk) begin
      if (mem_cs[i] && mem_we[i]) store[{10'd0, mem_addr[i]}] = bus;
    end

    always @(negedge clk) begin
      if (ram_drv) begin
        if (store.exists({10'd0, mem_addr[i]})) rd_q <= store[{10'd0, mem_addr[i]}];
        else rd_q <= 16'h0000;
      end
    end
  end

  always @(negedge clk) begin
    if ((mem_we & mem_oe) != 2'b00) overlap_n++;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One complete access on instance d. Checks latency, cs duration, bus
  // protocol while cs is high, and for reads the returned data and hold.
  task automatic access(input int d, input logic we, input logic [21:0] a,
                        input logic [15:0] wd, input int hold, input bit scramble,
                        input logic [15:0] exp);
    int  n;
    int  cs_n;
    int  perr;
    int  ws;
    bit  done;
    ws = (d == 0) ? 0 : 3;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready[d]), 32'd1);
    if (!req_ready[d]) return;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 0; cs_n = 0; perr = 0; done = 0;
    while (!done && n < 40) begin
      n++;
      if (scramble) begin
        req_addr[d]  = 22'($urandom);
        req_wdata[d] = 16'($urandom);
        req_we[d]    = ~we;
      end
      if (mem_cs[d]) begin
        cs_n++;
        if (mem_we[d] !== we || mem_oe[d] !== !we || mem_addr[d] !== a || req_ready[d])
          perr++;
        if (we && bus_seen[d] !== wd) perr++;
      end
      if (we ? (req_ready[d] && !mem_cs[d]) : resp_valid[d]) done = 1;
      else @(negedge clk);
    end
    chk(we ? "wr_latency" : "rd_latency", 32'(n - 1), 32'(1 + ws));
    chk(we ? "wr_cs_cycles" : "rd_cs_cycles", 32'(cs_n), 32'(1 + ws));
    chk("bus_proto", 32'(perr), 32'd0);
    if (!we && done) begin
      chk("rdata", 32'(resp_rdata[d]), 32'(exp));
      for (int i = 0; i < hold; i++) begin
        resp_ready[d] = 1'b0;
        @(negedge clk);
        chk("hold_flags", 32'({resp_valid[d], req_ready[d], mem_cs[d]}), 32'd4);
        chk("hold_rdata", 32'(resp_rdata[d]), 32'(exp));
      end
      resp_ready[d] = 1'b1;
      @(negedge clk);
      resp_ready[d] = 1'b0;
      chk("resp_done", 32'({resp_valid[d], req_ready[d]}), 32'd1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [15:0] wdata;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 22'h000100, 16'hBEEF, 0, 16'h0000};
    vecs[1] = '{1'b0, 22'h000100, 16'h0000, 0, 16'hBEEF};
    vecs[2] = '{1'b0, 22'h3FFFFF, 16'h0000, 5, 16'h1234};
    vecs[3] = '{1'b1, 22'h000010, 16'hFFFF, 0, 16'h0000};
    vecs[4] = '{1'b0, 22'h000010, 16'h0000, 0, 16'hFFFF};
    vecs[5] = '{1'b1, 22'h2AAAAA, 16'h5A5A, 0, 16'h0000};
    vecs[6] = '{1'b0, 22'h2AAAAA, 16'h0000, 1, 16'h5A5A};
    vecs[7] = '{1'b1, 22'h000100, 16'h0001, 0, 16'h0000};
    vecs[8] = '{1'b0, 22'h000100, 16'h0000, 0, 16'h0001};

    total = 0; bad = 0; overlap_n = 0;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; resp_ready = '0;
    g[0].store[32'h003FFFFF] = 16'h1234;
    g[1].store[32'h00000000] = 16'hA5A5;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_flags", 32'({req_ready[d], resp_valid[d], mem_cs[d], mem_we[d], mem_oe[d]}), 32'd0);
      chk("reset_addr", 32'(mem_addr[d]), 32'd0);
      chk("reset_rdata", 32'(resp_rdata[d]), 32'd0);
    end
    #2 rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_first_edge", 32'(req_ready), 32'd3);

    // Table-driven accesses, zero wait states, back to back.
    for (int v = 0; v < 9; v++)
      access(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].hold, 1'b0, vecs[v].exp);

    // Inputs toggled during the write must not reach the RAM.
    access(0, 1'b1, 22'h000020, 16'h0F0F, 0, 1'b1, 16'h0000);
    access(0, 1'b0, 22'h000020, 16'h0000, 0, 1'b0, 16'h0F0F);

    // Three wait states.
    access(1, 1'b0, 22'h000000, 16'h0000, 0, 1'b0, 16'hA5A5);
    access(1, 1'b1, 22'h000005, 16'h7777, 0, 1'b0, 16'h0000);
    access(1, 1'b0, 22'h000005, 16'h0000, 2, 1'b0, 16'h7777);

    // Asynchronous reset in the middle of a read on the wait-state instance.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 22'h000000;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("read_active", 32'({mem_cs[1], mem_oe[1]}), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_flags", 32'({mem_cs[1], mem_oe[1], resp_valid[1], req_ready[1]}), 32'd0);
    chk("async_reset_addr", 32'(mem_addr[1]), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_before_edge2", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_reset", 32'({req_ready[1], resp_valid[1], mem_cs[1]}), 32'd4);
    access(1, 1'b0, 22'h000000, 16'h0000, 0, 1'b0, 16'hA5A5);
    access(0, 1'b0, 22'h000100, 16'h0000, 0, 1'b0, 16'h0001);

    chk("we_oe_overlap", 32'(overlap_n), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
